roc_decoder: RTL and testbench
==============================

Name: roc_decoder

Overview:
- Receiving end of the rank-order-coded (ROC) index stream.
- Consumes sorted pixel indices (NEXT_INDEX / FOUND_NEXT_INDEX) from the ROC encoder and drives the AERIN_CTRL_BUSY handshake the encoder waits on.
- Reconstructs a rank image: the first index received gets PIXEL_MAX_VALUE, each later index gets one less.
- Sits in the interface path for loopback checking of the encoder and as the reference decoder of the ROC scheme.

Parameters:
IMAGE_SIZE, 7, number of pixels
IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), width of pixel index and rank counter
PIXEL_MAX_VALUE, 255, value assigned to rank 0
PIXEL_BITS, $clog2(PIXEL_MAX_VALUE), pixel value width
BUSY_CYCLES, 3, cycles AERIN_CTRL_BUSY stays high per accepted index (>=1)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
NEW_IMAGE  in  1  one-cycle pulse; clears the decoded image and starts a new frame
NEXT_INDEX  in  10  pixel index from encoder
FOUND_NEXT_INDEX  in  1  level; NEXT_INDEX is valid
ENCODER_RDY  in  1  encoder has finished sorting the frame
AERIN_CTRL_BUSY  out  1  handshake back to the encoder
DECODED_IMAGE  out  PIXEL_BITS x IMAGE_SIZE  unpacked array of reconstructed pixels
RANK_COUNT  out  IMAGE_SIZE_BITS+1  number of indices accepted this frame
DECODE_DONE  out  1  level; frame complete
DECODE_ERR  out  1  sticky; out-of-range or duplicate index seen this frame

Behaviour:
- Reset: all outputs 0, every DECODED_IMAGE entry 0, written-mask 0, FSM in IDLE.
- FSM states: IDLE, CAPTURE, BUSY, WAIT_LOW, DONE.
- IDLE: when FOUND_NEXT_INDEX=1, latch NEXT_INDEX and go to CAPTURE.
  - If ENCODER_RDY=1 and FOUND_NEXT_INDEX=0, go to DONE.
  - FOUND has priority when both are high.
- CAPTURE (1 cycle): validate the latched index and update state.
  - Valid means index < IMAGE_SIZE and its written-mask bit is 0.
  - Valid: DECODED_IMAGE[idx] <= PIXEL_MAX_VALUE - RANK_COUNT, saturating at 0; set the mask bit; RANK_COUNT++.
  - Invalid: no write, no count increment, set DECODE_ERR.
  - Next state is BUSY in both cases.
- BUSY: AERIN_CTRL_BUSY=1 for exactly BUSY_CYCLES cycles, beginning the cycle after CAPTURE.
  - Latency from FOUND rising to BUSY rising is 2 clocks.
  - Then go to WAIT_LOW.
- WAIT_LOW: AERIN_CTRL_BUSY=0.
  - Stay until FOUND_NEXT_INDEX=0, so one index is never consumed twice.
  - Then go to DONE if RANK_COUNT==IMAGE_SIZE, else IDLE.
- DONE: DECODE_DONE=1. FOUND_NEXT_INDEX is ignored and AERIN_CTRL_BUSY stays 0.
- NEW_IMAGE in any state, next cycle:
  - Clear the image, mask, RANK_COUNT, DECODE_DONE and DECODE_ERR.
  - Drop AERIN_CTRL_BUSY; an in-flight index is discarded.
  - Go to IDLE.
  - Priority over every other event in the same cycle.
- Only the low IMAGE_SIZE_BITS of NEXT_INDEX are used for addressing, and only after the full 10-bit range check passes.
- Frames cut short by ENCODER_RDY: unwritten pixels stay 0 and DECODE_DONE is still asserted.
- Reset mid-handshake: BUSY drops asynchronously and all state clears.

Decomposition:
- Shared package roc_pkg holds:
  - the FSM state enum (roc_dec_state_t);
  - the AER index width constant AER_INDEX_BITS=10;
  - the pixel array typedef, shared with the encoder.
- Sub-module roc_busy_timer: loadable down-counter that generates the BUSY_CYCLES pulse (load, active, expired). It is reusable on the encoder bench side.
- Everything else stays in roc_decoder.

Test Plan:
- Reset then stream indices 3,0,6,1,5,2,4, each with the encoder-style handshake (drop FOUND after BUSY is seen).
  - Expect DECODED_IMAGE = {254,252,250,255,249,251,253} at indices 0..6.
  - Expect RANK_COUNT=7 and DECODE_DONE=1 after the last WAIT_LOW.
- FOUND held high through the whole BUSY phase and 5 extra cycles with index 2.
  - Expect exactly one write (img[2]=255), RANK_COUNT=1, and BUSY high for exactly 3 cycles starting 2 clocks after FOUND.
- Indices 9 then 4 then 4.
  - Expect DECODE_ERR=1, img[4]=255, RANK_COUNT=1.
  - Expect BUSY still pulsed for each of the three indices.
- Indices 1,2, then ENCODER_RDY=1.
  - Expect img[1]=255, img[2]=254, all other pixels 0, DECODE_DONE=1 and RANK_COUNT=2.
- NEW_IMAGE pulsed during the 2nd BUSY cycle.
  - Expect BUSY=0 the next cycle, image and counters cleared, FSM back in IDLE.
  - A following index 0 gives img[0]=255.
- RST asserted asynchronously mid-BUSY.
  - Expect AERIN_CTRL_BUSY and all outputs at 0 before the next CLK edge.

Source files
------------

// File: rtl/roc_pkg.sv
// Shared definitions for the rank-order-coded (ROC) index stream.
// Holds the decoder FSM state encoding, the AER index width, and the
// default image geometry plus pixel/image types shared with the encoder.
package roc_pkg;

    // Width of the pixel index carried on the AER link.
    localparam int AER_INDEX_BITS = 10;

    // Default image geometry used by encoder and decoder.
    localparam int ROC_IMAGE_SIZE      = 7;
    localparam int ROC_PIXEL_MAX_VALUE = 255;
    localparam int ROC_PIXEL_BITS      = $clog2(ROC_PIXEL_MAX_VALUE);

    // Decoder handshake FSM states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_BUSY     = 3'd2,
        ST_WAIT_LOW = 3'd3,
        ST_DONE     = 3'd4
    } roc_dec_state_t;

    // Pixel and image types for the default geometry.
    typedef logic [ROC_PIXEL_BITS-1:0] roc_pixel_t;
    typedef roc_pixel_t roc_image_t [ROC_IMAGE_SIZE];

endpackage

// File: rtl/roc_busy_timer.sv
// Loadable down-counter producing a fixed-length busy window.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : synchronous clear, wins over load
//   load      : start a window of CYCLES cycles beginning next cycle
//   active    : high for every cycle of the window (registered)
//   expired   : high in the last cycle of the window (registered)
module roc_busy_timer
    import roc_pkg::*;
#(
    parameter int CYCLES   = 3,
    parameter int CNT_BITS = $clog2(CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    output logic active,
    output logic expired
);

    logic [CNT_BITS-1:0] count_r;
    logic [CNT_BITS-1:0] count_nxt_s;
    logic                active_r;
    logic                expired_r;

    // Next remaining-cycle count: clear, reload, or count down to zero.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = '0;
        end else if (load) begin
            count_nxt_s = CNT_BITS'(CYCLES);
        end else if (count_r != '0) begin
            count_nxt_s = count_r - CNT_BITS'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register; flags are derived from the next count so they are
    // themselves flops aligned with the count they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= '0;
            active_r  <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            active_r  <= (count_nxt_s != '0);
            expired_r <= (count_nxt_s == CNT_BITS'(1));
        end
    end

    assign active  = active_r;
    assign expired = expired_r;

endmodule

// File: rtl/roc_decoder.sv
// ROC decoder: receives sorted pixel indices from the ROC encoder, answers
// with the AERIN_CTRL_BUSY handshake and rebuilds a rank image where the
// first accepted index gets PIXEL_MAX_VALUE and each later one gets one less.
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset
//   NEW_IMAGE         : one-cycle pulse, clears the frame, highest priority
//   NEXT_INDEX        : pixel index from the encoder
//   FOUND_NEXT_INDEX  : level, NEXT_INDEX is valid
//   ENCODER_RDY       : encoder finished sorting the frame
//   AERIN_CTRL_BUSY   : handshake back to the encoder
//   DECODED_IMAGE     : reconstructed pixels
//   RANK_COUNT        : indices accepted this frame
//   DECODE_DONE       : level, frame complete
//   DECODE_ERR        : sticky, out-of-range or duplicate index seen
module roc_decoder
    import roc_pkg::*;
#(
    parameter int IMAGE_SIZE      = ROC_IMAGE_SIZE,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = ROC_PIXEL_MAX_VALUE,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
    parameter int BUSY_CYCLES     = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      NEW_IMAGE,
    input  logic [AER_INDEX_BITS-1:0] NEXT_INDEX,
    input  logic                      FOUND_NEXT_INDEX,
    input  logic                      ENCODER_RDY,
    output logic                      AERIN_CTRL_BUSY,
    output logic [PIXEL_BITS-1:0]     DECODED_IMAGE [IMAGE_SIZE],
    output logic [IMAGE_SIZE_BITS:0]  RANK_COUNT,
    output logic                      DECODE_DONE,
    output logic                      DECODE_ERR
);

    localparam int RANK_BITS = IMAGE_SIZE_BITS + 1;

    // Pixel value for a given rank, saturating at zero once the rank
    // reaches PIXEL_MAX_VALUE.
    function automatic logic [PIXEL_BITS-1:0] rank_value(input logic [RANK_BITS-1:0] rank);
        logic [31:0] rank32;
        rank32 = 32'(rank);
        if (rank32 >= 32'(PIXEL_MAX_VALUE)) begin
            return '0;
        end else begin
            return PIXEL_BITS'(32'(PIXEL_MAX_VALUE) - rank32);
        end
    endfunction

    roc_dec_state_t              state_r;
    roc_dec_state_t              state_nxt_s;
    logic [AER_INDEX_BITS-1:0]   idx_r;
    logic [IMAGE_SIZE_BITS-1:0]  addr_s;
    logic                        in_range_s;
    logic                        mask_hit_s;
    logic                        idx_valid_s;
    logic [IMAGE_SIZE-1:0]       mask_r;
    logic [PIXEL_BITS-1:0]       image_r [IMAGE_SIZE];
    logic [RANK_BITS-1:0]        rank_r;
    logic                        err_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        load_s;
    logic                        write_s;
    logic                        err_set_s;
    logic                        timer_active_s;
    logic                        timer_expired_s;

    roc_busy_timer #(
        .CYCLES (BUSY_CYCLES)
    ) u_busy_timer (
        .clk     (CLK),
        .rst     (RST),
        .clr     (NEW_IMAGE),
        .load    (load_s),
        .active  (timer_active_s),
        .expired (timer_expired_s)
    );

    // Validate the latched index: the full 10-bit value is range checked
    // before its low bits are trusted as an address.
    always_comb begin
        addr_s     = idx_r[IMAGE_SIZE_BITS-1:0];
        in_range_s = (idx_r < AER_INDEX_BITS'(IMAGE_SIZE));
        if (in_range_s) begin
            mask_hit_s = mask_r[addr_s];
        end else begin
            mask_hit_s = 1'b0;
        end
        idx_valid_s = in_range_s && !mask_hit_s;
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        write_s     = 1'b0;
        err_set_s   = 1'b0;
        if (NEW_IMAGE) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (FOUND_NEXT_INDEX) begin
                        state_nxt_s = ST_CAPTURE;
                    end else if (ENCODER_RDY) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_BUSY;
                    if (idx_valid_s) begin
                        write_s = 1'b1;
                    end else begin
                        err_set_s = 1'b1;
                    end
                end
                ST_BUSY: begin
                    // Leaving on a dead timer as well guards against a stuck window.
                    if (timer_expired_s || !timer_active_s) begin
                        state_nxt_s = ST_WAIT_LOW;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!FOUND_NEXT_INDEX) begin
                        if (rank_r == RANK_BITS'(IMAGE_SIZE)) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s = ST_WAIT_LOW;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register plus registered handshake/done flags, which follow
    // the state they are entering so they change on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_BUSY);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Frame datapath: index latch, written-mask, image, rank and error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_r  <= '0;
            mask_r <= '0;
            rank_r <= '0;
            err_r  <= 1'b0;
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                image_r[i] <= '0;
            end
        end else if (NEW_IMAGE) begin
            mask_r <= '0;
            rank_r <= '0;
            err_r  <= 1'b0;
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                image_r[i] <= '0;
            end
        end else begin
            if ((state_r == ST_IDLE) && FOUND_NEXT_INDEX) begin
                idx_r <= NEXT_INDEX;
            end
            if (write_s) begin
                image_r[addr_s] <= rank_value(rank_r);
                mask_r[addr_s]  <= 1'b1;
                rank_r          <= rank_r + RANK_BITS'(1);
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign AERIN_CTRL_BUSY = busy_r;
    assign DECODED_IMAGE   = image_r;
    assign RANK_COUNT      = rank_r;
    assign DECODE_DONE     = done_r;
    assign DECODE_ERR      = err_r;

endmodule

// File: tb/tb_roc_decoder.sv
// Directed self-checking bench for roc_decoder with hand-computed expectations.
module tb_roc_decoder;
    import roc_pkg::*;

    logic                      CLK;
    logic                      RST;
    logic                      NEW_IMAGE;
    logic [AER_INDEX_BITS-1:0] NEXT_INDEX;
    logic                      FOUND_NEXT_INDEX;
    logic                      ENCODER_RDY;
    logic                      AERIN_CTRL_BUSY;
    roc_image_t                img;
    logic [3:0]                RANK_COUNT;
    logic                      DECODE_DONE;
    logic                      DECODE_ERR;

    int errors = 0;
    int checks = 0;

    roc_decoder dut (
        .CLK              (CLK),
        .RST              (RST),
        .NEW_IMAGE        (NEW_IMAGE),
        .NEXT_INDEX       (NEXT_INDEX),
        .FOUND_NEXT_INDEX (FOUND_NEXT_INDEX),
        .ENCODER_RDY      (ENCODER_RDY),
        .AERIN_CTRL_BUSY  (AERIN_CTRL_BUSY),
        .DECODED_IMAGE    (img),
        .RANK_COUNT       (RANK_COUNT),
        .DECODE_DONE      (DECODE_DONE),
        .DECODE_ERR       (DECODE_ERR)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_image(input string tag, input roc_image_t exp);
        for (int i = 0; i < ROC_IMAGE_SIZE; i++) begin
            check_val($sformatf("%s_img%0d", tag, i), 32'(img[i]), 32'(exp[i]));
        end
    endtask

    // Encoder-style handshake: raise FOUND, drop it once BUSY is seen,
    // wait for BUSY to fall, then one idle cycle for WAIT_LOW to leave.
    task automatic send_index(input logic [AER_INDEX_BITS-1:0] idx);
        logic seen;
        logic fell;
        seen = 1'b0;
        fell = 1'b0;
        NEXT_INDEX       = idx;
        FOUND_NEXT_INDEX = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (AERIN_CTRL_BUSY) begin
                seen = 1'b1;
                break;
            end
        end
        FOUND_NEXT_INDEX = 1'b0;
        check_val($sformatf("busy_seen_idx%0d", idx), 32'(seen), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!AERIN_CTRL_BUSY) begin
                fell = 1'b1;
                break;
            end
        end
        check_val($sformatf("busy_fell_idx%0d", idx), 32'(fell), 32'd1);
        @(negedge CLK);
    endtask

    task automatic pulse_new_image();
        NEW_IMAGE = 1'b1;
        @(negedge CLK);
        NEW_IMAGE = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        roc_image_t zero_img;
        roc_image_t exp_img;
        logic [8:0] pattern;
        logic       seen;
        logic [AER_INDEX_BITS-1:0] seq [7];

        zero_img = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        seq      = '{10'd3, 10'd0, 10'd6, 10'd1, 10'd5, 10'd2, 10'd4};

        RST = 1'b1;
        NEW_IMAGE = 1'b0;
        NEXT_INDEX = '0;
        FOUND_NEXT_INDEX = 1'b0;
        ENCODER_RDY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Reset state
        check_val("rst_busy", 32'(AERIN_CTRL_BUSY), 32'd0);
        check_val("rst_rank", 32'(RANK_COUNT), 32'd0);
        check_val("rst_done", 32'(DECODE_DONE), 32'd0);
        check_val("rst_err",  32'(DECODE_ERR), 32'd0);
        check_image("rst", zero_img);

        // Full frame 3,0,6,1,5,2,4
        for (int k = 0; k < 7; k++) begin
            send_index(seq[k]);
            check_val($sformatf("frame_rank%0d", k), 32'(RANK_COUNT), 32'(k + 1));
        end
        exp_img = '{8'd254, 8'd252, 8'd250, 8'd255, 8'd249, 8'd251, 8'd253};
        check_image("frame", exp_img);
        check_val("frame_done", 32'(DECODE_DONE), 32'd1);
        check_val("frame_err",  32'(DECODE_ERR), 32'd0);

        // DONE ignores further indices
        NEXT_INDEX = 10'd0;
        FOUND_NEXT_INDEX = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (AERIN_CTRL_BUSY) seen = 1'b1;
        end
        FOUND_NEXT_INDEX = 1'b0;
        check_val("done_no_busy", 32'(seen), 32'd0);
        check_val("done_rank_hold", 32'(RANK_COUNT), 32'd7);

        // Clear, then FOUND held through BUSY and beyond with index 2
        pulse_new_image();
        check_val("clr_done", 32'(DECODE_DONE), 32'd0);
        check_val("clr_rank", 32'(RANK_COUNT), 32'd0);
        check_image("clr", zero_img);
        NEXT_INDEX = 10'd2;
        FOUND_NEXT_INDEX = 1'b1;
        pattern = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            pattern[i] = AERIN_CTRL_BUSY;
        end
        FOUND_NEXT_INDEX = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_val("hold_busy_window", 32'(pattern), 32'h0000_000E);
        check_val("hold_img2", 32'(img[2]), 32'd255);
        check_val("hold_rank", 32'(RANK_COUNT), 32'd1);
        check_val("hold_err",  32'(DECODE_ERR), 32'd0);

        // Out-of-range then duplicate
        pulse_new_image();
        send_index(10'd9);
        check_val("oor_err",  32'(DECODE_ERR), 32'd1);
        check_val("oor_rank", 32'(RANK_COUNT), 32'd0);
        check_val("oor_img1", 32'(img[1]), 32'd0);
        send_index(10'd4);
        send_index(10'd4);
        check_val("dup_err",  32'(DECODE_ERR), 32'd1);
        check_val("dup_img4", 32'(img[4]), 32'd255);
        check_val("dup_rank", 32'(RANK_COUNT), 32'd1);

        // Short frame ended by ENCODER_RDY
        pulse_new_image();
        check_val("clr2_err", 32'(DECODE_ERR), 32'd0);
        send_index(10'd1);
        send_index(10'd2);
        check_val("short_done_before", 32'(DECODE_DONE), 32'd0);
        ENCODER_RDY = 1'b1;
        @(negedge CLK);
        ENCODER_RDY = 1'b0;
        @(negedge CLK);
        exp_img = '{8'd0, 8'd255, 8'd254, 8'd0, 8'd0, 8'd0, 8'd0};
        check_image("short", exp_img);
        check_val("short_done", 32'(DECODE_DONE), 32'd1);
        check_val("short_rank", 32'(RANK_COUNT), 32'd2);

        // NEW_IMAGE during the second BUSY cycle
        pulse_new_image();
        send_index(10'd5);
        check_val("ni_pre_img5", 32'(img[5]), 32'd255);
        NEXT_INDEX = 10'd6;
        FOUND_NEXT_INDEX = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (AERIN_CTRL_BUSY) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("ni_busy_seen", 32'(seen), 32'd1);
        @(negedge CLK);
        check_val("ni_busy_2nd", 32'(AERIN_CTRL_BUSY), 32'd1);
        NEW_IMAGE = 1'b1;
        FOUND_NEXT_INDEX = 1'b0;
        @(negedge CLK);
        NEW_IMAGE = 1'b0;
        check_val("ni_busy_drop", 32'(AERIN_CTRL_BUSY), 32'd0);
        check_val("ni_rank", 32'(RANK_COUNT), 32'd0);
        check_val("ni_done", 32'(DECODE_DONE), 32'd0);
        check_image("ni", zero_img);
        @(negedge CLK);
        check_val("ni_busy_stay", 32'(AERIN_CTRL_BUSY), 32'd0);
        send_index(10'd0);
        check_val("ni_img0", 32'(img[0]), 32'd255);
        check_val("ni_rank_after", 32'(RANK_COUNT), 32'd1);

        // Asynchronous reset in the middle of BUSY
        NEXT_INDEX = 10'd3;
        FOUND_NEXT_INDEX = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (AERIN_CTRL_BUSY) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("arst_busy_seen", 32'(seen), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check_val("arst_busy", 32'(AERIN_CTRL_BUSY), 32'd0);
        check_val("arst_rank", 32'(RANK_COUNT), 32'd0);
        check_val("arst_done", 32'(DECODE_DONE), 32'd0);
        check_val("arst_err",  32'(DECODE_ERR), 32'd0);
        check_image("arst", zero_img);
        FOUND_NEXT_INDEX = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_val("arst_idle_busy", 32'(AERIN_CTRL_BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
